ffd_write_arbiter: RTL and testbench
====================================

FFD_WRITE_ARBITER -- requirements
Module: ffd_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the register.
REQ-002 Parameter WIDTH, default 4, width of the shared register.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  N_REQ  per-requester write request, level, held until own ack.
REQ-006 Port wdata  input  N_REQ*WIDTH  packed write data; slice i belongs to requester i.
REQ-007 Port ack  output  N_REQ  one-hot, one-cycle pulse to the requester whose write completed.
REQ-008 Port q  output  WIDTH  current contents of the shared register.
REQ-009 Port busy  output  1  high while state is not IDLE.
REQ-010 Port owner  output  clog2(N_REQ)  index of the last requester that wrote q.

Function
REQ-011 FSM SHALL have three states: IDLE, WRITE, ACK.
REQ-012 IDLE: if any req bit high, SHALL select winner round-robin starting at pointer ptr, latch winner index and its wdata slice, go to WRITE; else stay IDLE.
REQ-013 WRITE: register enable SHALL be high for exactly this one cycle; q loads latched data at the end of WRITE; go to ACK.
REQ-014 ACK: ack[winner] SHALL be high for exactly this cycle; owner updates to winner; ptr becomes (winner+1) mod N_REQ; go to IDLE.
REQ-015 Latency: req sampled high in IDLE at cycle n -> q updated visible at n+2 -> ack high at n+2 -> next arbitration at n+3.
REQ-016 Register enable SHALL be low in IDLE and ACK; q SHALL hold its value whenever enable is low.
REQ-017 Round-robin search SHALL wrap: ptr=3, req=4'b0011 -> winner 0.
REQ-018 Requester dropping req during WRITE or ACK SHALL NOT abort the write; ack still pulses.
REQ-019 wdata changes after the IDLE->WRITE edge SHALL NOT affect the value written.
REQ-020 Requester holding req after its ack SHALL be re-arbitrated with lowest priority (ptr already advanced).
REQ-021 At most one ack bit SHALL be high in any cycle; ack SHALL be all-zero outside ACK.
REQ-022 N_REQ not a power of two: ptr wrap SHALL use mod N_REQ, never reaching N_REQ.

Reset
REQ-023 reset high at a rising edge SHALL force state IDLE, ptr 0, owner 0, q 0, ack 0, busy 0, latched data 0, regardless of current state.
REQ-024 Reset asserted during WRITE SHALL prevent the pending load; q reads 0 after that edge; no ack is issued.
REQ-025 First arbitration after reset release SHALL treat requester 0 as highest priority.

Structure
REQ-026 Shared package SHALL hold the state encoding (IDLE=2'b00, WRITE=2'b01, ACK=2'b10) and default N_REQ/WIDTH constants.
REQ-027 The shared register SHALL be one sub-module reg_en: WIDTH-bit D register with clk, synchronous active-high reset, enable, d, q.
REQ-028 Arbitration, pointer and FSM SHALL live in ffd_write_arbiter; no other sub-modules.

Verification
REQ-029 Reset then req=4'b0100, wdata slice2=4'hA -> busy high next cycle, q=4'hA and ack=4'b0100 two cycles after, owner=2.
REQ-030 req=4'b1111 held constant, slice i = i+1 -> ack order 0,1,2,3,0 every 3 cycles; q sequence 1,2,3,4,1.
REQ-031 ptr=3 (after requester 2 write), req=4'b0011 -> winner 0, q=slice0.
REQ-032 req=4'b0001, wdata slice0=4'h5, change slice0 to 4'hF during WRITE and drop req -> q=4'h5, ack[0] still pulses.
REQ-033 reset asserted during WRITE with q previously 4'h7 -> q=0, no ack, state IDLE, ptr 0 next cycle.
REQ-034 req=0 for 20 cycles -> busy 0, ack 0, q unchanged throughout.

Source files
------------

// File: rtl/ffd_write_arbiter_pkg.sv
// Shared state encoding, default sizing and index-width helper for the
// round-robin shared-register write arbiter.
package ffd_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 4;

    // A single requester still needs a one-bit index so port widths stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ffd_write_arbiter_reg_en.sv
// WIDTH-bit D register with synchronous active-high reset and load enable;
// holds its contents whenever enable is low.
module reg_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ffd_write_arbiter.sv
// Round-robin arbiter letting N_REQ requesters write one shared register.
// Each grant takes IDLE -> WRITE -> ACK, so arbitration recurs every 3 cycles.
module ffd_write_arbiter
    import ffd_write_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*WIDTH-1:0]        wdata,
    output logic [N_REQ-1:0]              ack,
    output logic [WIDTH-1:0]              q,
    output logic                          busy,
    output logic [idx_width(N_REQ)-1:0]   owner
);

    localparam int               OW       = idx_width(N_REQ);
    localparam logic [OW-1:0]    LAST_IDX = OW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_t              r_state;
    logic [OW-1:0]       r_ptr;
    logic [OW-1:0]       r_win;
    logic [OW-1:0]       r_owner;
    logic [WIDTH-1:0]    r_data;
    logic [N_REQ-1:0]    r_ack;
    logic                r_busy;

    logic                w_found;
    logic [OW-1:0]       w_win;
    logic [OW-1:0]       w_next_ptr;
    logic [N_REQ-1:0]    w_win_onehot;
    logic                w_en;
    logic [WIDTH-1:0]    w_slice [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_slice[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search starts at r_ptr and wraps modulo N_REQ, so non power-of-two
    // requester counts never produce an out-of-range index.
    always_comb begin
        int            sum;
        logic [OW-1:0] idx;
        w_found = 1'b0;
        w_win   = '0;
        sum     = 0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(r_ptr) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            idx = OW'(sum);
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_next_ptr   = (r_win == LAST_IDX) ? '0 : r_win + 1'b1;
    assign w_win_onehot = ONE_HOT0 << r_win;
    assign w_en         = (r_state == ST_WRITE);

    // state | meaning
    // IDLE  | waiting for any req; arbitrates and latches winner + data
    // WRITE | shared register enable high for this one cycle
    // ACK   | ack pulse to winner, owner/ptr updated, back to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_owner <= '0;
            r_data  <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= '0;
                    if (w_found) begin
                        r_win   <= w_win;
                        r_data  <= w_slice[w_win];
                        r_busy  <= 1'b1;
                        r_state <= ST_WRITE;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    r_ack   <= w_win_onehot;
                    r_owner <= r_win;
                    r_ptr   <= w_next_ptr;
                    r_busy  <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    reg_en #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (w_en),
        .d      (r_data),
        .q      (q)
    );

    assign ack   = r_ack;
    assign busy  = r_busy;
    assign owner = r_owner;

endmodule

// File: tb/tb_ffd_write_arbiter.sv
// Self-checking bench for ffd_write_arbiter: directed scenarios plus random
// traffic against a transaction-level round-robin reference model.
module tb_ffd_write_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;
    logic [1:0]     owner;

    always #5 clk = ~clk;

    ffd_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .ack   (ack),
        .q     (q),
        .busy  (busy),
        .owner (owner)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one grant is a transaction started at edge m_start;
    // the register loads at m_start+1 and the arbiter is free again at m_start+3.
    int         edge_cnt = 0;
    bit         m_pend   = 0;
    int         m_start  = 0;
    int         m_win    = 0;
    int         m_ptr    = 0;
    int         m_owner  = 0;
    logic [W-1:0] m_q    = '0;
    logic [W-1:0] m_data = '0;

    int         ack_log[$];
    int         ack_edge[$];
    logic [W-1:0] q_log[$];

    task automatic cycle(input logic rst, input logic [N-1:0] r, input logic [N*W-1:0] wd);
        logic [N-1:0] e_ack;
        bit           was;
        bit           found;
        int           idx;
        @(negedge clk);
        reset = rst;
        req   = r;
        wdata = wd;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            m_pend  = 0;
            m_ptr   = 0;
            m_owner = 0;
            m_q     = '0;
        end else begin
            was = m_pend;
            if (m_pend && edge_cnt == m_start + 1) begin
                m_q     = m_data;
                m_owner = m_win;
                m_ptr   = (m_win + 1) % N;
            end
            if (m_pend && edge_cnt == m_start + 2) m_pend = 0;
            if (!was && r != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && r[idx]) begin
                        found = 1;
                        m_win = idx;
                    end
                end
                m_data  = wd[m_win*W +: W];
                m_pend  = 1;
                m_start = edge_cnt;
            end
        end
        e_ack = (m_pend && edge_cnt == m_start + 1) ? (N'(1) << m_win) : '0;
        #1;
        n_tests++;
        if (q !== m_q) begin
            n_fail++;
            $display("FAIL model_q edge %0d: got %h expected %h", edge_cnt, q, m_q);
        end
        n_tests++;
        if (ack !== e_ack) begin
            n_fail++;
            $display("FAIL model_ack edge %0d: got %b expected %b", edge_cnt, ack, e_ack);
        end
        n_tests++;
        if (busy !== m_pend) begin
            n_fail++;
            $display("FAIL model_busy edge %0d: got %b expected %b", edge_cnt, busy, m_pend);
        end
        n_tests++;
        if (owner !== 2'(m_owner)) begin
            n_fail++;
            $display("FAIL model_owner edge %0d: got %0d expected %0d", edge_cnt, owner, m_owner);
        end
        n_tests++;
        if ($countones(ack) > 1) begin
            n_fail++;
            $display("FAIL ack_onehot edge %0d: got %b expected at most one bit", edge_cnt, ack);
        end
        if (ack != '0) begin
            for (int k = 0; k < N; k++) if (ack[k]) ack_log.push_back(k);
            ack_edge.push_back(edge_cnt);
            q_log.push_back(q);
        end
    endtask

    task automatic clear_logs();
        ack_log.delete();
        ack_edge.delete();
        q_log.delete();
    endtask

    task automatic test_reset();
        cycle(1'b1, '0, '0);
        cycle(1'b1, '0, '0);
        n_tests++;
        if (q !== '0 || ack !== '0 || busy !== 1'b0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got q=%h ack=%b busy=%b owner=%0d expected all zero", q, ack, busy, owner);
        end
    endtask

    task automatic test_single();
        cycle(1'b0, 4'b0100, 16'h0A00);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: got %b expected 1", busy);
        end
        cycle(1'b0, 4'b0100, 16'h0A00);
        n_tests++;
        if (q !== 4'hA || ack !== 4'b0100 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL single_write: got q=%h ack=%b owner=%0d expected q=a ack=0100 owner=2", q, ack, owner);
        end
        cycle(1'b0, 4'b0000, 16'h0A00);
    endtask

    task automatic test_round_robin();
        int exp_idx[5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] exp_q[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        cycle(1'b1, '0, '0);
        clear_logs();
        for (int c = 0; c < 15; c++) cycle(1'b0, 4'b1111, 16'h4321);
        n_tests++;
        if (ack_log.size() != 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d acks expected 5", ack_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_tests++;
                if (ack_log[k] != exp_idx[k] || q_log[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: got idx=%0d q=%h expected idx=%0d q=%h", k, ack_log[k], q_log[k], exp_idx[k], exp_q[k]);
                end
                if (k > 0) begin
                    n_tests++;
                    if (ack_edge[k] - ack_edge[k-1] != 3) begin
                        n_fail++;
                        $display("FAIL rr_spacing[%0d]: got %0d expected 3", k, ack_edge[k] - ack_edge[k-1]);
                    end
                end
            end
        end
        cycle(1'b0, '0, 16'h4321);
        cycle(1'b0, '0, 16'h4321);
    endtask

    task automatic test_wrap();
        cycle(1'b1, '0, '0);
        cycle(1'b0, 4'b0100, 16'h0B00);
        cycle(1'b0, 4'b0100, 16'h0B00);
        cycle(1'b0, 4'b0000, 16'h0B00);
        clear_logs();
        cycle(1'b0, 4'b0011, 16'h0096);
        cycle(1'b0, 4'b0011, 16'h0096);
        n_tests++;
        if (ack_log.size() != 1 || ack_log[0] != 0 || q !== 4'h6) begin
            n_fail++;
            $display("FAIL wrap_winner: got acks=%0d q=%h expected winner 0 q=6", ack_log.size(), q);
        end
        cycle(1'b0, 4'b0010, 16'h0096);
        cycle(1'b0, 4'b0000, 16'h0096);
        cycle(1'b0, 4'b0000, 16'h0096);
    endtask

    task automatic test_wdata_change();
        clear_logs();
        cycle(1'b0, 4'b0001, 16'h0005);
        cycle(1'b0, 4'b0000, 16'h000F);
        n_tests++;
        if (q !== 4'h5 || ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL wdata_hold: got q=%h ack=%b expected q=5 ack=0001", q, ack);
        end
        cycle(1'b0, 4'b0000, 16'h000F);
    endtask

    task automatic test_reset_during_write();
        cycle(1'b0, 4'b0010, 16'h0070);
        cycle(1'b0, 4'b0010, 16'h0070);
        cycle(1'b0, 4'b0000, 16'h0070);
        n_tests++;
        if (q !== 4'h7) begin
            n_fail++;
            $display("FAIL rdw_setup: got q=%h expected 7", q);
        end
        cycle(1'b0, 4'b0001, 16'h0003);
        cycle(1'b1, 4'b0001, 16'h0003);
        n_tests++;
        if (q !== '0 || ack !== '0 || busy !== 1'b0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL rdw_abort: got q=%h ack=%b busy=%b owner=%0d expected all zero", q, ack, busy, owner);
        end
        cycle(1'b0, 4'b1001, 16'h5003);
        cycle(1'b0, 4'b1001, 16'h5003);
        n_tests++;
        if (ack !== 4'b0001 || q !== 4'h3) begin
            n_fail++;
            $display("FAIL rdw_first_prio: got ack=%b q=%h expected ack=0001 q=3", ack, q);
        end
        cycle(1'b0, 4'b0000, 16'h5003);
    endtask

    task automatic test_idle();
        logic [W-1:0] q_saved;
        int bad;
        cycle(1'b0, 4'b0000, 16'h0000);
        q_saved = q;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0, 4'b0000, 16'($urandom));
            if (busy !== 1'b0 || ack !== '0 || q !== q_saved) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %0d disturbed cycles expected 0", bad);
        end
    endtask

    task automatic test_random();
        logic rst;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            cycle(rst, 4'($urandom_range(0, 15)), 16'($urandom));
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_wdata_change();
        test_reset_during_write();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
